conv_3x3_seq: RTL and testbench

CONV_3X3_SEQ -- requirements
Module: conv_3x3_seq

---
 rtl/conv_3x3_seq_if.sv | 26 ++
 rtl/conv_3x3_seq.sv | 118 +++++++++++
 tb/tb_conv_3x3_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_3x3_seq_if.sv
// Stream-in / result-out bundle for conv_3x3_seq.
// Handshake rule for both channels: a word moves on a rising edge where valid
// and ready are both high. The source holds valid and data stable until that
// edge. The sink may raise or drop ready at any time.
interface conv_3x3_seq_if #(
  parameter int M = 32
);
  logic [M-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] res_data;
  logic         res_valid;
  logic         res_ready;

  // Producer of the stream and consumer of results (bench / upstream side).
  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_data, res_valid
  );

  // The convolution sequencer.
  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_data, res_valid
  );
endinterface

// File: rtl/conv_3x3_seq.sv
// Sequencer for a 3x3 convolution datapath.
// It streams 9 optional kernel words and 9 pixel words into the datapath.
// Kernel words go to addresses 9..17 and pixel words to addresses 0..8.
// After the datapath pipeline latency it captures the result and holds it
// until the result handshake completes.
module conv_3x3_seq #(
  parameter int M        = 32,
  parameter int PIPE_LAT = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                reload_k,
  output logic                busy,
  conv_3x3_seq_if.slave       io,
  output logic [M-1:0]        dp_a,
  output logic [4:0]          dp_addr,
  output logic                dp_en,
  input  logic [M-1:0]        dp_out,
  output logic [15:0]         win_cnt,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_LOAD_P = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam int CW = $clog2(PIPE_LAT + 1) + 1;
  localparam logic [4:0] PARK_ADDR = 5'd31;

  state_t        state, state_nxt;
  logic          k_loaded;
  logic [3:0]    idx;
  logic [CW-1:0] wait_cnt;

  logic accept;
  logic last_word;
  logic capture;
  logic release_res;

  assign io.in_ready = (state == S_LOAD_K) || (state == S_LOAD_P);
  assign accept      = io.in_valid && io.in_ready;
  assign last_word   = (idx == 4'd8);
  assign capture     = (state == S_WAIT) && (wait_cnt == CW'(PIPE_LAT));
  assign release_res = (state == S_OUT) && io.res_valid && io.res_ready;

  assign busy      = (state != S_IDLE);
  assign dp_en     = (state == S_WAIT);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (reload_k || !k_loaded) ? S_LOAD_K : S_LOAD_P;
      S_LOAD_K: if (accept && last_word) state_nxt = S_LOAD_P;
      S_LOAD_P: if (accept && last_word) state_nxt = S_WAIT;
      S_WAIT:   if (capture) state_nxt = S_OUT;
      S_OUT:    if (release_res) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Word index, kernel-valid flag and pipeline wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      k_loaded <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (accept) idx <= last_word ? 4'd0 : idx + 4'd1;
      if (state == S_LOAD_K && accept && last_word) k_loaded <= 1'b1;
      if (state == S_LOAD_P && accept && last_word) wait_cnt <= '0;
      else if (state == S_WAIT)                     wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Datapath write port. The datapath writes every clock, so cycles without
  // an accepted word are steered to the park address with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_addr <= PARK_ADDR;
      dp_a    <= '0;
    end else if (accept) begin
      dp_addr <= (state == S_LOAD_K) ? (5'd9 + 5'(idx)) : 5'(idx);
      dp_a    <= io.in_data;
    end else begin
      dp_addr <= PARK_ADDR;
      dp_a    <= '0;
    end
  end

  // Result capture, hold and window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      io.res_data  <= '0;
      io.res_valid <= 1'b0;
      win_cnt      <= '0;
    end else if (capture) begin
      io.res_data  <= dp_out;
      io.res_valid <= 1'b1;
      win_cnt      <= win_cnt + 16'd1;
    end else if (release_res) begin
      io.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_3x3_seq.sv
// Directed bench for conv_3x3_seq with a behavioural datapath model and
// queue-based scoreboards for datapath writes and results.
module tb_conv_3x3_seq;
  localparam int M        = 32;
  localparam int PIPE_LAT = 12;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_K = 3'd1;
  localparam logic [2:0] ST_LOAD_P = 3'd2;
  localparam logic [2:0] ST_OUT    = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          reload_k;
  logic          busy;
  logic [M-1:0]  dp_a;
  logic [4:0]    dp_addr;
  logic          dp_en;
  logic [M-1:0]  dp_out;
  logic [15:0]   win_cnt;
  logic [2:0]    dbg_state;

  conv_3x3_seq_if #(.M(M)) io ();

  conv_3x3_seq #(.M(M), .PIPE_LAT(PIPE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reload_k  (reload_k),
    .busy      (busy),
    .io        (io),
    .dp_a      (dp_a),
    .dp_addr   (dp_addr),
    .dp_en     (dp_en),
    .dp_out    (dp_out),
    .win_cnt   (win_cnt),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  logic rst_q = 1'b0;
  always @(posedge clk) rst_q <= rst;

  // Behavioural datapath: writes every clock, result is the 9-tap dot product.
  logic [M-1:0] mem [32];
  logic [M-1:0] acc;
  always @(posedge clk) mem[dp_addr] <= dp_a;
  always_comb begin
    acc = '0;
    for (int i = 0; i < 9; i++) acc = acc + mem[9 + i] * mem[i];
    dp_out = dp_en ? acc : '0;
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [M-1:0] exp_q[$];
  logic [4:0]   exp_addr_q[$];
  logic [M-1:0] exp_a_q[$];
  logic         last_word = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic do_start(input logic rk, input logic [2:0] exp_state);
    @(posedge clk); #1;
    start = 1'b1; reload_k = rk;
    @(posedge clk); #1;
    start = 1'b0; reload_k = 1'b0;
    check("state_after_start", dbg_state, exp_state);
  endtask

  task automatic send_word(input logic [M-1:0] data, input logic [4:0] addr,
                           input logic last, input int gap);
    int n;
    io.in_data = data; io.in_valid = 1'b1; last_word = last; n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!io.in_ready) begin
      check("in_ready_timeout", 0, 1);
      io.in_valid = 1'b0; last_word = 1'b0;
    end else begin
      @(posedge clk);
      exp_addr_q.push_back(addr);
      exp_a_q.push_back(data);
      #1;
      io.in_valid = 1'b0; last_word = 1'b0; io.in_data = '0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
  endtask

  task automatic send_kernel(input logic [M-1:0] base, input logic [M-1:0] step);
    for (int i = 0; i < 9; i++) send_word(base + step * i, 5'(9 + i), 1'b0, 0);
  endtask

  task automatic send_pixels(input logic [M-1:0] base, input logic [M-1:0] step, input int gap);
    for (int i = 0; i < 9; i++) send_word(base + step * i, 5'(i), i == 8, gap);
  endtask

  task automatic wait_done(input logic [15:0] exp_win);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    #1;
    check("result_timeout", exp_q.size(), 0);
    check("state_idle_after_handshake", dbg_state, ST_IDLE);
    check("win_cnt", win_cnt, exp_win);
    check("res_valid_cleared", io.res_valid, 0);
  endtask

  // Monitor: datapath writes, dp_en window, latency and results
  int   cyc = 0;
  int   p8_cyc = 0;
  int   en_left = 0;
  logic last_acc = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_q) begin
      check("rst_dp_addr", dp_addr, 31);
      check("rst_dp_a", dp_a, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", io.in_ready, 0);
      check("rst_dp_en", dp_en, 0);
      check("rst_res_valid", io.res_valid, 0);
      check("rst_res_data", io.res_data, 0);
      check("rst_win_cnt", win_cnt, 0);
      check("rst_state", dbg_state, ST_IDLE);
      exp_addr_q.delete();
      exp_a_q.delete();
      last_acc = 1'b0; en_left = 0; prev_valid = 1'b0;
    end else begin
      if (last_acc) begin
        if (exp_addr_q.size() == 0) check("addr_queue_nonempty", 0, 1);
        else begin
          check("dp_addr", dp_addr, exp_addr_q.pop_front());
          check("dp_a", dp_a, exp_a_q.pop_front());
        end
      end else begin
        check("dp_addr_park", dp_addr, 31);
        check("dp_a_park", dp_a, 0);
      end
      check("dp_en", dp_en, en_left > 0);
      if (en_left > 0) en_left--;
      if (io.res_valid && !prev_valid) check("latency_from_p8", cyc - p8_cyc, PIPE_LAT + 2);
      if (io.res_valid && io.res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 0, 1);
        else check("res_data", io.res_data, exp_q.pop_front());
      end
      prev_valid = io.res_valid;
      last_acc = io.in_valid && io.in_ready;
      if (last_acc && last_word) begin
        en_left = PIPE_LAT + 1;
        p8_cyc = cyc;
      end
    end
  end

  // Main stimulus
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; reload_k = 1'b0;
    io.in_valid = 1'b0; io.in_data = '0; io.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Window 1: forced kernel load, kernel all 1, pixels 1..9 -> 45
    do_start(1'b0, ST_LOAD_K);
    exp_q.push_back(45);
    send_kernel(1, 0);
    send_pixels(1, 1, 0);
    wait_done(16'd1);

    // Window 2: kernel kept, pixels all 2 -> 18
    do_start(1'b0, ST_LOAD_P);
    exp_q.push_back(18);
    send_pixels(2, 0, 0);
    wait_done(16'd2);

    // Window 3: gapped stream, pixels 1..9 -> 45
    do_start(1'b0, ST_LOAD_P);
    exp_q.push_back(45);
    send_pixels(1, 1, 1);
    wait_done(16'd3);

    // Window 4: result back-pressure, pixels all 3 -> 27
    io.res_ready = 1'b0;
    do_start(1'b0, ST_LOAD_P);
    exp_q.push_back(27);
    send_pixels(3, 0, 0);
    n = 0;
    while (!io.res_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("res_valid_rise", io.res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; reload_k = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0; reload_k = 1'b0;
      check("hold_res_valid", io.res_valid, 1);
      check("hold_res_data", io.res_data, 27);
      check("hold_state", dbg_state, ST_OUT);
      check("hold_busy", busy, 1);
    end
    io.res_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bp_state_idle", dbg_state, ST_IDLE);
    check("bp_win_cnt", win_cnt, 4);
    check("bp_exp_consumed", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("bp_start_ignored", dbg_state, ST_IDLE);

    // Window 5: reset at pixel p4, then forced reload
    do_start(1'b0, ST_LOAD_P);
    for (int i = 0; i < 4; i++) send_word(M'(5), 5'(i), 1'b0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_win_cnt", win_cnt, 0);
    check("post_rst_res_valid", io.res_valid, 0);
    check("post_rst_busy", busy, 0);
    do_start(1'b0, ST_LOAD_K);
    exp_q.push_back(285);
    send_kernel(1, 1);
    send_pixels(1, 1, 0);
    wait_done(16'd1);
    repeat (4) @(posedge clk);
    #1 check("final_no_stale_valid", io.res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
